// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the M-stage data-memory access unit.
package osiris_i_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

  typedef enum logic [1:0] {IDLE, REQ, DONE} mem_state_t;
endpackage

// File: rtl/mem_access_unit_if.sv
// Single-beat req/ack data-memory bus between the access unit and memory.
interface mem_access_unit_if #(parameter int DATA_WIDTH = 32);
  logic                  req;
  logic                  we;
  logic [DATA_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [3:0]            be;
  logic                  ack;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/mem_access_unit_align.sv
// Byte-lane steering: store enables/replication, load lane select/extension, size checks.
module mem_align
  import osiris_i_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            addr_lo_i,
  input  logic [2:0]            funct3_i,
  input  logic                  is_store_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [3:0]            be_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  misaligned_o,
  output logic                  illegal_o
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign half_sel = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

  always_comb begin
    be_o         = '0;
    wdata_o      = '0;
    rdata_o      = '0;
    misaligned_o = 1'b0;
    illegal_o    = 1'b0;
    case (funct3_i)
      F3_B: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      end
      F3_H: begin
        be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o      = {2{wdata_i[15:0]}};
        rdata_o      = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
        misaligned_o = addr_lo_i[0];
      end
      F3_W: begin
        be_o         = 4'b1111;
        wdata_o      = wdata_i;
        rdata_o      = rdata_i;
        misaligned_o = (addr_lo_i != 2'b00);
      end
      F3_BU: begin
        rdata_o   = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
        illegal_o = is_store_i;
      end
      F3_HU: begin
        rdata_o      = {{(DATA_WIDTH-16){1'b0}}, half_sel};
        misaligned_o = addr_lo_i[0];
        illegal_o    = is_store_i;
      end
      default: illegal_o = 1'b1;
    endcase
    // Loads always fetch the whole word; the lane is picked on return.
    if (!is_store_i) be_o = 4'b1111;
  end
endmodule

// File: rtl/mem_access_unit.sv
// M-stage load/store unit: issues one bus beat per access and stalls until it completes.
module mem_access_unit
  import osiris_i_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid_M,
  input  logic [DATA_WIDTH-1:0]  i_alu_result_M,
  input  logic [DATA_WIDTH-1:0]  i_write_data_M,
  input  logic                   i_mem_write_M,
  input  logic [1:0]             i_result_src_M,
  input  logic [2:0]             i_funct3_M,
  mem_access_unit_if.master      dmem,
  output logic [DATA_WIDTH-1:0]  o_read_data_M,
  output logic                   o_stall_M,
  output logic                   o_fault_M
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]            be_q, be_d;
  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            alo_q, alo_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  req;

  logic                  is_store, is_load, access;
  logic [1:0]            al_addr;
  logic [2:0]            al_f3;
  logic [3:0]            al_be;
  logic [DATA_WIDTH-1:0] al_wdata, al_rdata;
  logic                  al_mis, al_ill;

  assign is_store = i_mem_write_M;
  assign is_load  = !i_mem_write_M && (i_result_src_M == RESULT_SRC_MEM);
  assign access   = i_valid_M && (is_store || is_load);

  // Decode live inputs in IDLE; extend returning data with the latched size/lane.
  assign al_addr = (state_q == IDLE) ? i_alu_result_M[1:0] : alo_q;
  assign al_f3   = (state_q == IDLE) ? i_funct3_M : f3_q;

  mem_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .addr_lo_i    (al_addr),
    .funct3_i     (al_f3),
    .is_store_i   ((state_q == IDLE) ? is_store : we_q),
    .wdata_i      (i_write_data_M),
    .rdata_i      (dmem.rdata),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .rdata_o      (al_rdata),
    .misaligned_o (al_mis),
    .illegal_o    (al_ill)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      alo_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      alo_q   <= alo_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    be_d      = be_q;
    we_d      = we_q;
    f3_d      = f3_q;
    alo_d     = alo_q;
    cnt_d     = cnt_q;
    req       = 1'b0;
    o_stall_M = 1'b0;
    o_fault_M = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (access) begin
          if (al_mis || al_ill) begin
            o_fault_M = 1'b1;
            rdata_d   = '0;
          end else begin
            addr_d    = {i_alu_result_M[DATA_WIDTH-1:2], 2'b00};
            wdata_d   = al_wdata;
            be_d      = al_be;
            we_d      = is_store;
            f3_d      = i_funct3_M;
            alo_d     = i_alu_result_M[1:0];
            o_stall_M = 1'b1;
            state_d   = REQ;
          end
        end
      end
      REQ: begin
        req       = 1'b1;
        o_stall_M = 1'b1;
        if (dmem.ack) begin
          if (!we_q) rdata_d = al_rdata;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          o_fault_M = 1'b1;
          rdata_d   = '0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // One non-stalled cycle lets the instruction leave M before we look again.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign dmem.req      = req;
  assign dmem.we       = req && we_q;
  assign dmem.be       = req ? be_q : 4'b0000;
  assign dmem.addr     = addr_q;
  assign dmem.wdata    = wdata_q;
  assign o_read_data_M = rdata_q;
endmodule
